bus_arbiter: RTL and testbench

//  Shares the single FEPU->BEPU peripheral bus (select/w/data/addr) between two masters.
//  m0 is the CPU front end (FEPU); m1 is a secondary master (debug/DMA loader).

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master peripheral bus arbiter.
package bus_arbiter_pkg;

    // Ownership state of the shared FEPU->BEPU bus.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // Default tenure bound while the other master waits.
    localparam int unsigned ARB_MAX_BURST = 8;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between the CPU front end
// (m0) and a secondary debug/DMA master (m1), with a bounded burst tenure.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = ARB_MAX_BURST,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned SELW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_w,
    input  logic [SELW-1:0] m0_sel,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    input  logic            m1_req,
    input  logic            m1_w,
    input  logic [SELW-1:0] m1_sel,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic [SELW-1:0] bus_sel,
    output logic            bus_w,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic            bus_busy
);

    localparam int unsigned    CW       = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    arb_state_e    r_state;
    logic          r_last;
    logic [CW-1:0] r_cnt;

    arb_state_e    w_state_nxt;
    logic          w_last_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pick1;

    // Round-robin picker: on a tie the master that did not own last wins.
    always_comb begin
        w_pick1 = m1_req & (~m0_req | ~r_last);
    end

    // State, last-owner and burst counter registers; last=1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: grant from idle, bounded tenure under contention, release handover.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    w_state_nxt = w_pick1 ? ARB_OWN1 : ARB_OWN0;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_OWN0: begin
                if (m0_req) begin
                    // Counter only advances while m1 waits, so it never exceeds CNT_LAST.
                    if (m1_req) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ARB_OWN1;
                            w_last_nxt  = 1'b0;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end else begin
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = m1_req ? ARB_OWN1 : ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (m1_req) begin
                    if (m0_req) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ARB_OWN0;
                            w_last_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end else begin
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = m0_req ? ARB_OWN0 : ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Grant decode and bus mux from state; write strobe and select gated by the owner's req.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        bus_sel   = '0;
        bus_w     = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (r_state)
            ARB_OWN0: begin
                m0_gnt    = 1'b1;
                bus_sel   = m0_req ? m0_sel : '0;
                bus_w     = m0_req & m0_w;
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
            end
            ARB_OWN1: begin
                m1_gnt    = 1'b1;
                bus_sel   = m1_req ? m1_sel : '0;
                bus_w     = m1_req & m1_w;
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
            end
            default: ;
        endcase
        bus_busy = m0_gnt | m1_gnt;
    end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus multi-cycle sequences.
module tb_bus_arbiter;

    localparam logic [31:0] M0_SEL = 32'h1, M0_ADDR = 32'h20, M0_DATA = 32'h5A;
    localparam logic [31:0] M1_SEL = 32'h4, M1_ADDR = 32'h10, M1_DATA = 32'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_w, m1_req, m1_w;
    logic [31:0] m0_sel, m0_addr, m0_wdata, m1_sel, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, bus_w, bus_busy;
    logic [31:0] bus_sel, bus_addr, bus_wdata;
    logic        b_m0_gnt, b_m1_gnt, b_bus_w, b_bus_busy;
    logic [31:0] b_bus_sel, b_bus_addr, b_bus_wdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_BURST(8), .AW(32), .DW(32), .SELW(32)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_w(m0_w), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m1_req(m1_req), .m1_w(m1_w), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .bus_sel(bus_sel), .bus_w(bus_w), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_busy(bus_busy)
    );

    bus_arbiter #(.MAX_BURST(1), .AW(32), .DW(32), .SELW(32)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_w(m0_w), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(b_m0_gnt),
        .m1_req(m1_req), .m1_w(m1_w), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(b_m1_gnt),
        .bus_sel(b_bus_sel), .bus_w(b_bus_w), .bus_addr(b_bus_addr),
        .bus_wdata(b_bus_wdata), .bus_busy(b_bus_busy)
    );

    typedef struct {
        logic        r, q0, q1;
        logic        e_g0, e_g1, e_w, e_busy;
        logic [31:0] e_sel, e_addr, e_data;
    } vec_t;

    vec_t tbl [12];

    // owner: 0 = none, 1 = m0, 2 = m1 (expected after the edge that samples the inputs)
    function automatic vec_t mk(input logic r, input logic q0, input logic q1, input int owner);
        vec_t v;
        v.r = r; v.q0 = q0; v.q1 = q1;
        v.e_g0 = (owner == 1); v.e_g1 = (owner == 2); v.e_busy = (owner != 0);
        v.e_w = (owner != 0);
        v.e_sel  = (owner == 1) ? M0_SEL  : (owner == 2) ? M1_SEL  : 32'h0;
        v.e_addr = (owner == 1) ? M0_ADDR : (owner == 2) ? M1_ADDR : 32'h0;
        v.e_data = (owner == 1) ? M0_DATA : (owner == 2) ? M1_DATA : 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_w = 1'b1; m0_sel = M0_SEL; m0_addr = M0_ADDR; m0_wdata = M0_DATA;
        m1_w = 1'b1; m1_sel = M1_SEL; m1_addr = M1_ADDR; m1_wdata = M1_DATA;

        // Reset held with both requesting, then release: m0 wins the first tie
        rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_g0", 32'(m0_gnt), 32'h0);
        chk("rst_g1", 32'(m1_gnt), 32'h0);
        chk("rst_sel", bus_sel, 32'h0);
        chk("rst_w", 32'(bus_w), 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_data", bus_wdata, 32'h0);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_g0", 32'(m0_gnt), 32'h1);
        chk("rel_g1", 32'(m1_gnt), 32'h0);

        // Table of single-edge vectors from idle
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 2);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 2);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 2);
        tbl[10] = mk(1'b0, 1'b1, 1'b1, 0);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 1);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = tbl[i].r; m0_req = tbl[i].q0; m1_req = tbl[i].q1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_g0", i), 32'(m0_gnt), 32'(tbl[i].e_g0));
            chk($sformatf("v%0d_g1", i), 32'(m1_gnt), 32'(tbl[i].e_g1));
            chk($sformatf("v%0d_sel", i), bus_sel, tbl[i].e_sel);
            chk($sformatf("v%0d_w", i), 32'(bus_w), 32'(tbl[i].e_w));
            chk($sformatf("v%0d_addr", i), bus_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_data", i), bus_wdata, tbl[i].e_data);
            chk($sformatf("v%0d_busy", i), 32'(bus_busy), 32'(tbl[i].e_busy));
        end

        // Owner drops req mid-cycle: strobe/select gated at once, idle after the edge
        do_reset();
        @(negedge clk); m1_req = 1'b1;
        @(posedge clk); #1;
        chk("drop_pre_g1", 32'(m1_gnt), 32'h1);
        chk("drop_pre_w", 32'(bus_w), 32'h1);
        @(negedge clk); m1_req = 1'b0; #1;
        chk("drop_w", 32'(bus_w), 32'h0);
        chk("drop_sel", bus_sel, 32'h0);
        chk("drop_g1", 32'(m1_gnt), 32'h1);
        @(posedge clk); #1;
        chk("drop_busy", 32'(bus_busy), 32'h0);

        // Sustained contention: blocks of 8 (and alternation every cycle for MAX_BURST=1)
        do_reset();
        @(negedge clk); m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk($sformatf("alt%0d_g0", i), 32'(m0_gnt), 32'(((i / 8) % 2) == 0));
            chk($sformatf("alt%0d_g1", i), 32'(m1_gnt), 32'(((i / 8) % 2) == 1));
            chk($sformatf("alt%0d_sel", i), bus_sel, (((i / 8) % 2) == 0) ? M0_SEL : M1_SEL);
            chk($sformatf("alt%0d_b1g0", i), 32'(b_m0_gnt), 32'((i % 2) == 0));
            chk($sformatf("alt%0d_b1g1", i), 32'(b_m1_gnt), 32'((i % 2) == 1));
        end

        // Early release hands straight over; new owner gets a full fresh tenure
        do_reset();
        @(negedge clk); m0_req = 1'b1; m1_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); m0_req = 1'b0;
        @(posedge clk); #1;
        chk("early_g1", 32'(m1_gnt), 32'h1);
        chk("early_g0", 32'(m0_gnt), 32'h0);
        chk("early_busy", 32'(bus_busy), 32'h1);
        @(negedge clk); m0_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("early%0d_g1", k), 32'(m1_gnt), 32'(k < 8));
            chk($sformatf("early%0d_g0", k), 32'(m0_gnt), 32'(k == 8));
        end

        // Asynchronous reset during an m1 write
        do_reset();
        @(negedge clk); m1_req = 1'b1;
        @(posedge clk); #1;
        chk("mrst_pre_w", 32'(bus_w), 32'h1);
        @(negedge clk); rst = 1'b0; #1;
        chk("mrst_g1", 32'(m1_gnt), 32'h0);
        chk("mrst_w", 32'(bus_w), 32'h0);
        chk("mrst_busy", 32'(bus_busy), 32'h0);
        chk("mrst_addr", bus_addr, 32'h0);
        m1_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_idle", 32'(bus_busy), 32'h0);
        @(negedge clk); m1_req = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rereq", 32'(m1_gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_bus_arbiter
